// File: rtl/basket_controller.sv
// basket_controller: shopping-basket table of (product ID, quantity) entries.
// Sequences add (search + merge/append), cancel (shift-compaction) and clear
// operations behind a busy/done handshake. It also provides a registered read
// port for the display.
module basket_controller #(
    parameter int NUM_SLOTS = 8,
    parameter int ID_W      = 4,
    parameter int QTY_W     = 3,
    parameter int IDX_W     = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             add_req,
    input  logic [ID_W-1:0]  add_id,
    input  logic [QTY_W-1:0] add_qty,
    input  logic             cancel_req,
    input  logic [IDX_W-1:0] cancel_idx,
    input  logic             clear_req,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic             sat,
    output logic [IDX_W:0]   count,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ID_W-1:0]  rd_id,
    output logic [QTY_W-1:0] rd_qty,
    output logic             rd_valid
);

    typedef enum logic [2:0] {
        IDLE, SEARCH, MERGE, APPEND, SHIFT, CLEAR, DONE
    } state_t;

    localparam logic [1:0]     ST_OK_NEW    = 2'b00;
    localparam logic [1:0]     ST_OK_MERGED = 2'b01;
    localparam logic [1:0]     ST_ERR_FULL  = 2'b10;
    localparam logic [1:0]     ST_ERR_ARG   = 2'b11;
    localparam logic [IDX_W:0] FULL_COUNT   = (IDX_W+1)'(NUM_SLOTS);
    localparam logic [QTY_W:0] QTY_MAX      = {1'b0, {QTY_W{1'b1}}};

    state_t           state_reg;
    logic [IDX_W:0]   count_reg;
    logic [IDX_W:0]   ptr_reg;      // search slot / shift destination slot
    logic [IDX_W:0]   last_reg;     // index of the last valid slot when a cancel starts
    logic [ID_W-1:0]  op_id_reg;
    logic [QTY_W-1:0] op_qty_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             sat_reg;
    logic [1:0]       status_reg;

    logic [ID_W-1:0]  id_mem  [NUM_SLOTS];
    logic [QTY_W-1:0] qty_mem [NUM_SLOTS];

    logic [ID_W-1:0]  rd_id_reg;
    logic [QTY_W-1:0] rd_qty_reg;
    logic             rd_valid_reg;

    // Slot-write decode shared by merge, append and shift.
    logic [IDX_W-1:0]     ptr_idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic [QTY_W:0]       merge_sum;
    logic                 merge_clip;
    logic [QTY_W-1:0]     merge_qty;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_sel;
    logic [ID_W-1:0]      wr_id;
    logic [QTY_W-1:0]     wr_qty;
    logic                 clr_all;
    logic [NUM_SLOTS-1:0] slot_hit;

    assign ptr_idx    = ptr_reg[IDX_W-1:0];
    assign nxt_idx    = ptr_idx + 1'b1;
    assign merge_sum  = {1'b0, qty_mem[ptr_idx]} + {1'b0, op_qty_reg};
    assign merge_clip = (merge_sum > QTY_MAX);
    assign merge_qty  = merge_clip ? {QTY_W{1'b1}} : merge_sum[QTY_W-1:0];
    assign clr_all    = (state_reg == CLEAR);

    // Select which slot (if any) is written this cycle and with what data.
    always_comb begin
        wr_en  = 1'b0;
        wr_sel = '0;
        wr_id  = '0;
        wr_qty = '0;
        case (state_reg)
            MERGE: begin
                wr_en  = 1'b1;
                wr_sel = ptr_idx;
                wr_id  = id_mem[ptr_idx];
                wr_qty = merge_qty;
            end
            APPEND: begin
                wr_en  = (count_reg != FULL_COUNT);
                wr_sel = count_reg[IDX_W-1:0];
                wr_id  = op_id_reg;
                wr_qty = op_qty_reg;
            end
            SHIFT: begin
                if (ptr_reg < last_reg) begin
                    wr_en  = 1'b1;
                    wr_sel = ptr_idx;
                    wr_id  = id_mem[nxt_idx];
                    wr_qty = qty_mem[nxt_idx];
                end else if (ptr_reg == last_reg) begin
                    // The vacated tail slot is zeroed so slots >= count stay zero.
                    wr_en  = 1'b1;
                    wr_sel = ptr_idx;
                end
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
            assign slot_hit[gi] = wr_en && (wr_sel == IDX_W'(gi));
        end
    endgenerate

    // Basket table storage: reset/clear zero every slot, otherwise write the decoded slot.
    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (RESET || clr_all) begin
                id_mem[k]  <= '0;
                qty_mem[k] <= '0;
            end else if (slot_hit[k]) begin
                id_mem[k]  <= wr_id;
                qty_mem[k] <= wr_qty;
            end
        end
    end

    // Operation sequencer with registered handshake and result outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            ptr_reg    <= '0;
            last_reg   <= '0;
            op_id_reg  <= '0;
            op_qty_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sat_reg    <= 1'b0;
            status_reg <= ST_OK_NEW;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        busy_reg  <= 1'b1;
                        state_reg <= CLEAR;
                    end else if (cancel_req) begin
                        busy_reg <= 1'b1;
                        if ({1'b0, cancel_idx} >= count_reg) begin
                            state_reg  <= DONE;
                            done_reg   <= 1'b1;
                            status_reg <= ST_ERR_ARG;
                            sat_reg    <= 1'b0;
                        end else begin
                            state_reg <= SHIFT;
                            ptr_reg   <= {1'b0, cancel_idx};
                            last_reg  <= count_reg - 1'b1;
                        end
                    end else if (add_req) begin
                        busy_reg   <= 1'b1;
                        op_id_reg  <= add_id;
                        op_qty_reg <= add_qty;
                        ptr_reg    <= '0;
                        if (add_qty == '0) begin
                            state_reg  <= DONE;
                            done_reg   <= 1'b1;
                            status_reg <= ST_ERR_ARG;
                            sat_reg    <= 1'b0;
                        end else begin
                            state_reg <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // The final cycle (ptr == count) is the "not found" decision.
                    if (ptr_reg == count_reg) begin
                        state_reg <= APPEND;
                    end else if (id_mem[ptr_idx] == op_id_reg) begin
                        state_reg <= MERGE;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                MERGE: begin
                    state_reg  <= DONE;
                    done_reg   <= 1'b1;
                    status_reg <= ST_OK_MERGED;
                    sat_reg    <= merge_clip;
                end
                APPEND: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                    sat_reg   <= 1'b0;
                    if (count_reg != FULL_COUNT) begin
                        count_reg  <= count_reg + 1'b1;
                        status_reg <= ST_OK_NEW;
                    end else begin
                        status_reg <= ST_ERR_FULL;
                    end
                end
                SHIFT: begin
                    // Copy cycles, then the zero/decrement cycle, then one settle cycle.
                    if (ptr_reg < last_reg) begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end else if (ptr_reg == last_reg) begin
                        count_reg <= count_reg - 1'b1;
                        ptr_reg   <= ptr_reg + 1'b1;
                    end else begin
                        state_reg  <= DONE;
                        done_reg   <= 1'b1;
                        status_reg <= ST_OK_NEW;
                        sat_reg    <= 1'b0;
                    end
                end
                CLEAR: begin
                    count_reg  <= '0;
                    state_reg  <= DONE;
                    done_reg   <= 1'b1;
                    status_reg <= ST_OK_NEW;
                    sat_reg    <= 1'b0;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Display read port: one-cycle latency over the live table; empty slots read as zero.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_id_reg    <= '0;
            rd_qty_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else if ({1'b0, rd_idx} < count_reg) begin
            rd_id_reg    <= id_mem[rd_idx];
            rd_qty_reg   <= qty_mem[rd_idx];
            rd_valid_reg <= 1'b1;
        end else begin
            rd_id_reg    <= '0;
            rd_qty_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign status   = status_reg;
    assign sat      = sat_reg;
    assign count    = count_reg;
    assign rd_id    = rd_id_reg;
    assign rd_qty   = rd_qty_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_basket_controller.sv
// Testbench for basket_controller (NUM_SLOTS=4): directed scenarios followed by
// random add/cancel/clear traffic, checked against a queue-based basket model.
module tb_basket_controller;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       add_req, cancel_req, clear_req;
    logic [3:0] add_id;
    logic [2:0] add_qty;
    logic [1:0] cancel_idx, rd_idx;
    logic       busy, done, sat, rd_valid;
    logic [1:0] status;
    logic [2:0] count;
    logic [3:0] rd_id;
    logic [2:0] rd_qty;

    typedef struct {
        logic [3:0] id;
        logic [2:0] qty;
    } ent_t;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;

    basket_controller #(.NUM_SLOTS(4), .ID_W(4), .QTY_W(3), .IDX_W(2)) dut (
        .CLOCK_50(clk), .RESET(rst),
        .add_req(add_req), .add_id(add_id), .add_qty(add_qty),
        .cancel_req(cancel_req), .cancel_idx(cancel_idx), .clear_req(clear_req),
        .busy(busy), .done(done), .status(status), .sat(sat), .count(count),
        .rd_idx(rd_idx), .rd_id(rd_id), .rd_qty(rd_qty), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read every slot through the display port and compare with the model.
    task automatic verify_table();
        for (int i = 0; i < NS; i++) begin
            rd_idx = 2'(i);
            step();
            if (i < mq.size()) begin
                chk($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'd1);
                chk($sformatf("rd_id[%0d]", i), 32'(rd_id), 32'(mq[i].id));
                chk($sformatf("rd_qty[%0d]", i), 32'(rd_qty), 32'(mq[i].qty));
            end else begin
                chk($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'd0);
                chk($sformatf("rd_id[%0d]", i), 32'(rd_id), 32'd0);
                chk($sformatf("rd_qty[%0d]", i), 32'(rd_qty), 32'd0);
            end
        end
    endtask

    // kind: 0 add, 1 cancel, 2 clear. Model predicts latency/status/sat, then DUT is run.
    task automatic run_op(input int kind, input logic [3:0] id, input logic [2:0] qty,
                          input logic [1:0] idx);
        int         exp_lat, cyc, m, sum;
        logic [1:0] exp_st;
        logic       exp_sat;
        string      name;
        exp_sat = 1'b0;
        exp_st  = 2'b00;
        if (kind == 0) begin
            name = $sformatf("add(%0d,%0d)", id, qty);
            m = -1;
            for (int k = 0; k < mq.size(); k++)
                if (m < 0 && mq[k].id == id) m = k;
            if (qty == 0) begin
                exp_lat = 1; exp_st = 2'b11;
            end else if (m >= 0) begin
                exp_lat = m + 3; exp_st = 2'b01;
                sum = int'(mq[m].qty) + int'(qty);
                if (sum > 7) begin
                    sum = 7; exp_sat = 1'b1;
                end
                mq[m].qty = 3'(sum);
            end else if (mq.size() < NS) begin
                exp_lat = mq.size() + 3; exp_st = 2'b00;
                mq.push_back('{id: id, qty: qty});
            end else begin
                exp_lat = mq.size() + 3; exp_st = 2'b10;
            end
        end else if (kind == 1) begin
            name = $sformatf("cancel(%0d)", idx);
            if (int'(idx) >= mq.size()) begin
                exp_lat = 1; exp_st = 2'b11;
            end else begin
                exp_lat = (mq.size() - 1 - int'(idx)) + 3;
                mq.delete(int'(idx));
            end
        end else begin
            name = "clear";
            exp_lat = 2;
            mq.delete();
        end

        add_req    = (kind == 0);
        cancel_req = (kind == 1);
        clear_req  = (kind == 2);
        add_id     = id;
        add_qty    = qty;
        cancel_idx = idx;
        step();
        add_req = 1'b0; cancel_req = 1'b0; clear_req = 1'b0;
        cyc = 1;
        chk({name, " busy_after_accept"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk({name, " done_seen"}, 32'(done), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, " status"}, 32'(status), 32'(exp_st));
        chk({name, " sat"}, 32'(sat), 32'(exp_sat));
        chk({name, " count"}, 32'(count), 32'(mq.size()));
        chk({name, " busy_in_done"}, 32'(busy), 32'd1);
        step();
        chk({name, " busy_after"}, 32'(busy), 32'd0);
        chk({name, " done_pulse"}, 32'(done), 32'd0);
        $display("op %-12s lat=%0d status=%0d sat=%0d count=%0d", name, cyc, status, sat, count);
        verify_table();
    endtask

    initial begin
        rst = 1'b1;
        add_req = 1'b0; cancel_req = 1'b0; clear_req = 1'b0;
        add_id = '0; add_qty = '0; cancel_idx = '0; rd_idx = '0;
        repeat (3) step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset status", 32'(status), 32'd0);
        chk("reset sat", 32'(sat), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        step();
        verify_table();

        // First add, merges and saturation.
        run_op(0, 4'd5, 3'd2, 2'd0);
        run_op(0, 4'd5, 3'd3, 2'd0);
        run_op(0, 4'd5, 3'd4, 2'd0);
        run_op(0, 4'd6, 3'd0, 2'd0);

        // Fill the basket, then overflow it.
        run_op(2, 4'd0, 3'd0, 2'd0);
        for (int i = 1; i <= 4; i++) run_op(0, 4'(i), 3'd1, 2'd0);
        run_op(0, 4'd9, 3'd1, 2'd0);
        run_op(0, 4'd4, 3'd2, 2'd0);

        // Cancel from the middle, then out of range.
        run_op(1, 4'd0, 3'd0, 2'd1);
        run_op(1, 4'd0, 3'd0, 2'd3);
        run_op(1, 4'd0, 3'd0, 2'd2);

        // Simultaneous clear+add: clear wins; an add during busy is dropped.
        add_req = 1'b1; clear_req = 1'b1; add_id = 4'd3; add_qty = 3'd1;
        step();
        clear_req = 1'b0; add_id = 4'd6; add_qty = 3'd2;
        chk("prio busy", 32'(busy), 32'd1);
        chk("prio done_early", 32'(done), 32'd0);
        step();
        add_req = 1'b0;
        chk("prio done", 32'(done), 32'd1);
        chk("prio count", 32'(count), 32'd0);
        chk("prio status", 32'(status), 32'd0);
        mq.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("prio no_extra_done", 32'(done), 32'd0);
        end
        chk("prio busy_idle", 32'(busy), 32'd0);
        chk("prio count_final", 32'(count), 32'd0);
        $display("op clear+add  only clear executed, count=%0d", count);
        verify_table();

        // Reset asserted during a SHIFT aborts the cancel with no done pulse.
        for (int i = 1; i <= 4; i++) run_op(0, 4'(i + 10), 3'd2, 2'd0);
        cancel_req = 1'b1; cancel_idx = 2'd0;
        step();
        cancel_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_shift busy", 32'(busy), 32'd0);
        chk("rst_shift done", 32'(done), 32'd0);
        chk("rst_shift count", 32'(count), 32'd0);
        mq.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_shift no_done", 32'(done), 32'd0);
        end
        $display("op reset-in-shift count=%0d busy=%0d", count, busy);
        verify_table();

        // Random traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)
                run_op(0, 4'($urandom_range(0, 6)), 3'($urandom_range(0, 4)), 2'd0);
            else if (r <= 8)
                run_op(1, 4'd0, 3'd0, 2'($urandom_range(0, 3)));
            else
                run_op(2, 4'd0, 3'd0, 2'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
